sn54ls32_bist: RTL
==================

// Module: sn54ls32_bist
// PURPOSE
// - Sequential self-test driver/checker for a quad 2-input gate chip (SN54LS32 OR by default).
// - Drives the eight gate inputs from registered outputs and samples the four gate outputs.
// - Compares each sampled output with the expected function and reports pass/fail per gate.
// - Synthesizable counterpart to the gate-level testbenches; sits beside the gate model in board-level sims.
// PARAMETERS
// - GATE_FN        0        expected function: 0=OR, 1=AND, 2=NAND, 3=NOR, 4=XOR; other values behave as OR
// - SETTLE_CYCLES  2        wait cycles between driving a vector and sampling; legal range 1..15
// PORTS
// - i_clk          in   1   clock; all state updates on rising edge
// - i_rst_n        in   1   asynchronous reset, active-low
// - i_start        in   1   one-cycle start request; accepted only in IDLE
// - i_abort        in   1   abandon the current run
// - i_1Y..i_4Y     in   1   gate outputs under test
// - o_1A,o_1B..o_4A,o_4B out 1 each   registered gate input drives
// - o_busy         out  1   high from accepted start until DONE exits
// - o_done         out  1   one-cycle pulse at run completion (not pulsed on abort)
// - o_pass         out  1   run completed with zero errors; held until next start, abort or reset
// - o_fail_mask    out  4   sticky per-gate failure flags; bit n-1 = gate n
// - o_err_cnt      out  8   count of failing vectors (any gate mismatch); saturates at 255
// BEHAVIOUR
// - Reset (async, i_rst_n=0): all outputs 0; FSM=IDLE; vector index=first vector.
// - FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
// - IDLE: i_start=1 -> DRIVE; same edge clears o_fail_mask, o_err_cnt, o_pass; o_busy=1 from next cycle.
// - DRIVE (1 cycle): load current vector into o_xA/o_xB -> SETTLE.
// - SETTLE: count SETTLE_CYCLES cycles; drives held stable -> CHECK.
// - CHECK (1 cycle): sample i_1Y..i_4Y; expected = GATE_FN(o_nA,o_nB) per gate.
//   Mismatch on gate n sets o_fail_mask[n-1]; any mismatch increments o_err_cnt once (saturating).
//   Last vector -> DONE; otherwise advance index -> DRIVE.
// - DONE (1 cycle): o_done=1; o_pass=(o_err_cnt==0, including CHECK update); o_busy=0 next cycle; -> IDLE.
// - Cycles per vector = SETTLE_CYCLES+2; start-to-o_done = N*(SETTLE_CYCLES+2)+1 cycles after start edge.
// - Default vector set (N=4), all gates driven identically, order A/B = 11, 10, 01, 00.
// - i_start while not IDLE ignored; no queuing.
// - i_abort (any non-IDLE state) has priority over all transitions: -> IDLE next edge, drives=0,
//   o_busy=0, o_pass=0, o_done not pulsed; o_fail_mask/o_err_cnt keep partial values.
// - i_abort and i_start in same IDLE cycle: abort wins, start ignored.
// - Reset mid-run: immediate return to reset values; no completion reported.
// - Drives change only in DRIVE, abort or reset; never in SETTLE/CHECK.
// CONFIGURATION
// - SN54LS32_BIST_EXHAUSTIVE_EN defined: N=256; 8-bit index counts 8'hFF down to 8'h00;
//   gate n gets A=idx[2n-1], B=idx[2n-2] (gate 1 = idx[1:0]); detects cross-gate shorts.
// - Not defined: 4-vector set above, 2-bit index; no 8-bit counter logic generated.
// TESTING
// - Ideal OR model, SETTLE_CYCLES=2, start -> o_done 17 cycles after start edge, o_pass=1, mask=4'b0000, err=0.
// - 2Y stuck-at-0 -> o_fail_mask=4'b0010, o_err_cnt=3, o_pass=0.
// - 4Y stuck-at-1 -> fails only vector 00: o_fail_mask=4'b1000, o_err_cnt=1.
// - GATE_FN=1 (AND) against OR model -> vectors 10,01 fail all gates: o_fail_mask=4'b1111, o_err_cnt=2.
// - i_abort during SETTLE of vector 2 -> IDLE next edge, drives 0, o_busy=0, no o_done; start while busy ignored.
// - EXHAUSTIVE_EN, ideal OR, SETTLE_CYCLES=1 -> o_done after 769 cycles, pass=1; 1Y/2Y shorted (OR-tied) -> mask=4'b0011.

Source files
------------

// File: rtl/sn54ls32_bist.sv
// ============================================================================
// Module      : sn54ls32_bist
// Description : Sequential self-test driver/checker for a quad 2-input gate
//               chip (SN54LS32 OR by default). Optional exhaustive 256-vector
//               mode enabled by defining SN54LS32_BIST_EXHAUSTIVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sn54ls32_bist #(
  parameter int GATE_FN       = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_1Y,
  input  logic       i_2Y,
  input  logic       i_3Y,
  input  logic       i_4Y,
  output logic       o_1A,
  output logic       o_1B,
  output logic       o_2A,
  output logic       o_2B,
  output logic       o_3A,
  output logic       o_3B,
  output logic       o_4A,
  output logic       o_4B,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_fail_mask,
  output logic [7:0] o_err_cnt
);

`ifdef SN54LS32_BIST_EXHAUSTIVE_EN
  localparam int IDX_W = 8;
`else
  localparam int IDX_W = 2;
`endif
  localparam logic [IDX_W-1:0] C_IDX_FIRST   = '1;
  localparam logic [3:0]       C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       drv_q, drv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [3:0]       mask_q, mask_d;
  logic [7:0]       err_q, err_d;

  logic [7:0]       w_vec_drv;
  logic [3:0]       w_exp_y;
  logic [3:0]       w_mismatch;

  function automatic logic gate_expect(input logic a, input logic b);
    case (GATE_FN)
      1:       gate_expect = a & b;
      2:       gate_expect = ~(a & b);
      3:       gate_expect = ~(a | b);
      4:       gate_expect = a ^ b;
      default: gate_expect = a | b;
    endcase
  endfunction

  // Gate n is driven from bits {2n-1, 2n-2} of the drive word.
`ifdef SN54LS32_BIST_EXHAUSTIVE_EN
  assign w_vec_drv = idx_q;
`else
  assign w_vec_drv = {4{idx_q}};
`endif

  genvar n;
  generate
    for (n = 0; n < 4; n++) begin : g_gate
      assign w_exp_y[n] = gate_expect(drv_q[2*n+1], drv_q[2*n]);
    end
  endgenerate

  assign w_mismatch = {i_4Y, i_3Y, i_2Y, i_1Y} ^ w_exp_y;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    err_d   = err_q;

    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = C_IDX_FIRST;
      cnt_d   = 4'd0;
      drv_d   = 8'd0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            state_d = S_DRIVE;
            idx_d   = C_IDX_FIRST;
            busy_d  = 1'b1;
            pass_d  = 1'b0;
            mask_d  = 4'd0;
            err_d   = 8'd0;
          end
        end
        S_DRIVE: begin
          drv_d   = w_vec_drv;
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == C_SETTLE_LAST) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_CHECK: begin
          mask_d = mask_q | w_mismatch;
          if ((w_mismatch != 4'd0) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_DRIVE;
          end
        end
        S_DONE: begin
          // err_q already holds the final CHECK update here.
          done_d  = 1'b1;
          pass_d  = (err_q == 8'd0);
          busy_d  = 1'b0;
          idx_d   = C_IDX_FIRST;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= C_IDX_FIRST;
      cnt_q   <= 4'd0;
      drv_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= 4'd0;
      err_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  assign {o_4A, o_4B, o_3A, o_3B, o_2A, o_2B, o_1A, o_1B} = drv_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_fail_mask = mask_q;
  assign o_err_cnt   = err_q;

endmodule

`default_nettype wire
